// File: rtl/ext_pkg.sv
// Shared types for the immediate/shift-amount extension pipeline:
// extension modes and the handshake FSM state encoding.
package ext_pkg;

   typedef enum logic [1:0] {
      EXT_SIGN   = 2'b00,
      EXT_ZERO   = 2'b01,
      EXT_UPPER  = 2'b10,
      EXT_BRANCH = 2'b11
   } ext_mode_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b10
   } ext_state_t;

endpackage

// File: rtl/ext_core.sv
// Combinational field extender: widens an IN_W-bit field to OUT_W bits
// under one of the four extension modes.
module ext_core
   import ext_pkg::*;
#(
   parameter int unsigned IN_W     = 5,
   parameter int unsigned OUT_W    = 32,
   parameter int unsigned BR_SHIFT = 2
) (
   input  logic [IN_W-1:0]  data,
   input  ext_mode_t        mode,
   output logic [OUT_W-1:0] result
);

   if (IN_W > OUT_W || IN_W + BR_SHIFT > OUT_W) begin : g_bad_param
      $error("ext_core: IN_W and IN_W+BR_SHIFT must not exceed OUT_W");
   end

   logic [OUT_W-1:0] zext;
   logic [OUT_W-1:0] sext;

   assign zext = OUT_W'(data);
   assign sext = OUT_W'($signed(data));

   // Branch mode shifts at full width, so the top BR_SHIFT bits fall off.
   always_comb begin
      result = zext;
      case (mode)
         EXT_SIGN:   result = sext;
         EXT_ZERO:   result = zext;
         EXT_UPPER:  result = zext << (OUT_W - IN_W);
         EXT_BRANCH: result = sext << BR_SHIFT;
         default:    result = zext;
      endcase
   end

endmodule

// File: rtl/ext_unit_pipe.sv
// Registered extension unit with valid/ready handshakes and a one-entry skid
// register behind the output register; full throughput under backpressure.
module ext_unit_pipe
   import ext_pkg::*;
#(
   parameter int unsigned IN_W     = 5,
   parameter int unsigned OUT_W    = 32,
   parameter int unsigned BR_SHIFT = 2,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [CNT_W-1:0] xfer_count
);

   if (IN_W > OUT_W || IN_W + BR_SHIFT > OUT_W) begin : g_bad_param
      $error("ext_unit_pipe: IN_W and IN_W+BR_SHIFT must not exceed OUT_W");
   end

   ext_state_t       state, state_nx;
   logic [OUT_W-1:0] skid;
   logic [OUT_W-1:0] ext_val;
   logic             accept, deliver;
   logic             load_out, load_skid, skid_to_out;

   ext_core #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .BR_SHIFT(BR_SHIFT)
   ) u_core (
      .data  (in_data),
      .mode  (ext_mode_t'(in_mode)),
      .result(ext_val)
   );

   // Both flags decode registered state only; no path from out_ready.
   assign in_ready  = (state != ST_TWO);
   assign out_valid = (state != ST_EMPTY);
   assign accept    = in_valid & in_ready;
   assign deliver   = out_valid & out_ready;

   always_comb begin
      state_nx    = state;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               state_nx = ST_ONE;
               load_out = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && deliver) begin
               load_out = 1'b1;
            end else if (accept) begin
               state_nx  = ST_TWO;
               load_skid = 1'b1;
            end else if (deliver) begin
               state_nx = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (deliver) begin
               state_nx    = ST_ONE;
               skid_to_out = 1'b1;
            end
         end
         default: state_nx = ST_EMPTY;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= ST_EMPTY;
         out_data   <= '0;
         skid       <= '0;
         xfer_count <= '0;
      end else begin
         state <= state_nx;
         if (load_out)
            out_data <= ext_val;
         else if (skid_to_out)
            out_data <= skid;
         if (load_skid)
            skid <= ext_val;
         if (deliver)
            xfer_count <= xfer_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Bench for ext_unit_pipe: two instances (5-bit field with 4-bit counter,
// 16-bit field with 16-bit counter) checked against an arithmetic FIFO model.
module tb_ext_unit_pipe;
   import ext_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance A: IN_W=5, CNT_W=4
   logic        v5, ir5, ov5, or5;
   logic [4:0]  d5;
   logic [1:0]  m5;
   logic [31:0] od5;
   logic [3:0]  xc5;

   // Instance B: IN_W=16, CNT_W=16
   logic        v16, ir16, ov16, or16;
   logic [15:0] d16;
   logic [1:0]  m16;
   logic [31:0] od16;
   logic [15:0] xc16;

   ext_unit_pipe #(.IN_W(5), .OUT_W(32), .BR_SHIFT(2), .CNT_W(4)) dut5 (
      .Clk(clk), .Rst(rst), .in_valid(v5), .in_ready(ir5), .in_data(d5), .in_mode(m5),
      .out_valid(ov5), .out_ready(or5), .out_data(od5), .xfer_count(xc5));

   ext_unit_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2), .CNT_W(16)) dut16 (
      .Clk(clk), .Rst(rst), .in_valid(v16), .in_ready(ir16), .in_data(d16), .in_mode(m16),
      .out_valid(ov16), .out_ready(or16), .out_data(od16), .xfer_count(xc16));

   int checks = 0;
   int failures = 0;
   logic [31:0] q5[$];
   logic [31:0] q16[$];
   int c5, c16;
   logic del5, del16;

   // Extension from the mode rules with plain integer arithmetic.
   function automatic logic [31:0] ref_ext(longint d, int m, int w);
      longint s, r;
      s = (d >= (longint'(1) << (w - 1))) ? d - (longint'(1) << w) : d;
      case (m)
         0: r = s;
         1: r = d;
         2: r = d * (longint'(1) << (32 - w));
         default: r = s * 4;
      endcase
      return 32'(r);
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: settle handshakes against the model, advance, check state.
   task automatic tick();
      del5 = 1'b0;
      del16 = 1'b0;
      if (rst) begin
         q5.delete(); q16.delete(); c5 = 0; c16 = 0;
      end else begin
         if (ov5 && or5) begin
            del5 = 1'b1;
            if (q5.size() > 0) chk("deliver5", 64'(od5), 64'(q5.pop_front()));
            c5++;
         end
         if (v5 && ir5) q5.push_back(ref_ext(longint'(d5), int'(m5), 5));
         if (ov16 && or16) begin
            del16 = 1'b1;
            if (q16.size() > 0) chk("deliver16", 64'(od16), 64'(q16.pop_front()));
            c16++;
         end
         if (v16 && ir16) q16.push_back(ref_ext(longint'(d16), int'(m16), 16));
      end
      @(posedge clk);
      #1;
      chk("in_ready5", 64'(ir5), 64'(q5.size() < 2));
      chk("out_valid5", 64'(ov5), 64'(q5.size() > 0));
      chk("xfer5", 64'(xc5), 64'(c5 % 16));
      chk("in_ready16", 64'(ir16), 64'(q16.size() < 2));
      chk("out_valid16", 64'(ov16), 64'(q16.size() > 0));
      chk("xfer16", 64'(xc16), 64'(c16 % 65536));
      if (q5.size() > 0) chk("head5", 64'(od5), 64'(q5[0]));
      if (q16.size() > 0) chk("head16", 64'(od16), 64'(q16[0]));
   endtask

   task automatic idle_inputs();
      v5 = 0; d5 = '0; m5 = 2'b00; or5 = 0;
      v16 = 0; d16 = '0; m16 = 2'b00; or16 = 0;
   endtask

   initial begin
      int n;
      rst = 1'b1;
      idle_inputs();
      v5 = 1; v16 = 1; d5 = 5'h1f; d16 = 16'hffff;
      tick(); tick();
      rst = 1'b0;
      idle_inputs();
      chk("rst_data5", 64'(od5), 64'h0);
      chk("rst_data16", 64'(od16), 64'h0);
      chk("rst_ready5", 64'(ir5), 64'h1);

      // Directed extension values, each visible one cycle after accept
      or5 = 1; or16 = 1;
      v5 = 1; d5 = 5'b10110; m5 = EXT_SIGN;
      v16 = 1; d16 = 16'h1234; m16 = EXT_UPPER;
      tick();
      chk("sign5_neg", 64'(od5), 64'hFFFFFFF6);
      chk("upper16", 64'(od16), 64'h12340000);
      m5 = EXT_ZERO; d16 = 16'h8000; m16 = EXT_BRANCH;
      tick();
      chk("zero5", 64'(od5), 64'h00000016);
      chk("branch16_neg", 64'(od16), 64'hFFFE0000);
      d5 = 5'b00110; m5 = EXT_SIGN; d16 = 16'h0003;
      tick();
      chk("sign5_pos", 64'(od5), 64'h00000006);
      chk("branch16_pos", 64'(od16), 64'h0000000C);
      v5 = 0; v16 = 0;
      tick();

      // Backpressure on instance B: A to output, B to skid, C held
      rst = 1; tick(); rst = 0; idle_inputs();
      v16 = 1; d16 = 16'h000A; m16 = EXT_ZERO;
      tick();
      d16 = 16'h000B;
      tick();
      chk("bp_ready_low", 64'(ir16), 64'h0);
      d16 = 16'h000C;
      tick();
      chk("bp_hold_A", 64'(od16), 64'h0000000A);
      or16 = 1;
      tick();
      chk("bp_B", 64'(od16), 64'h0000000B);
      tick();
      chk("bp_C", 64'(od16), 64'h0000000C);
      v16 = 0;
      tick();
      chk("bp_count", 64'(xc16), 64'h3);

      // Streaming on instance B: one result per cycle
      rst = 1; tick(); rst = 0; idle_inputs();
      v16 = 1; or16 = 1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         d16 = 16'($urandom); m16 = 2'($urandom);
         tick();
         if (del16) n++;
         chk("stream_ready", 64'(ir16), 64'h1);
      end
      v16 = 0;
      tick();
      if (del16) n++;
      chk("stream_count", 64'(n), 64'd20);
      chk("stream_xfer", 64'(xc16), 64'd20);

      // Reset while instance B holds two entries; no stale data afterwards
      idle_inputs();
      v16 = 1; d16 = 16'h00AA; m16 = EXT_ZERO;
      tick(); tick();
      chk("two_full", 64'(ir16), 64'h0);
      rst = 1; tick(); rst = 0;
      chk("post_rst_valid", 64'(ov16), 64'h0);
      chk("post_rst_ready", 64'(ir16), 64'h1);
      chk("post_rst_xfer", 64'(xc16), 64'h0);
      d16 = 16'h0055;
      tick();
      v16 = 0; or16 = 1;
      chk("post_rst_first", 64'(od16), 64'h00000055);
      tick();
      chk("post_rst_one", 64'(xc16), 64'h1);

      // Counter wrap on instance A (4-bit counter)
      rst = 1; tick(); rst = 0; idle_inputs();
      v5 = 1; or5 = 1;
      n = 0;
      for (int i = 0; i < 19; i++) begin
         if (i >= 17) v5 = 0;
         d5 = 5'($urandom); m5 = 2'($urandom);
         tick();
         if (del5) begin
            n++;
            if (n == 15) chk("wrap15", 64'(xc5), 64'd15);
            if (n == 16) chk("wrap16", 64'(xc5), 64'd0);
            if (n == 17) chk("wrap17", 64'(xc5), 64'd1);
         end
      end
      chk("wrap_total", 64'(n), 64'd17);

      // Randomized traffic on both instances
      rst = 1; tick(); rst = 0; idle_inputs();
      for (int i = 0; i < 400; i++) begin
         v5 = 1'($urandom); or5 = ($urandom_range(3) != 0);
         d5 = 5'($urandom); m5 = 2'($urandom);
         v16 = 1'($urandom); or16 = ($urandom_range(3) != 0);
         d16 = 16'($urandom); m16 = 2'($urandom);
         if (i % 97 == 96) rst = 1; else rst = 0;
         tick();
      end
      rst = 0; idle_inputs(); or5 = 1; or16 = 1;
      tick(); tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
